// File: rtl/fs_pkg.sv
// Shared types and default geometry for the FAST-9 scan controller.
package fs_pkg;

   localparam int FS_IMG_W   = 128;
   localparam int FS_IMG_H   = 128;
   localparam int FS_BORDER  = 3;
   localparam int FS_ADDR_W  = 15;
   localparam int FS_SCORE_W = 8;
   localparam int FS_THRES_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } fs_scan_state_t;

   // A frame with no interior pixels skips straight from IDLE to DONE.
   function automatic bit fs_frame_empty(input int w, input int h, input int b);
      return (w <= 2 * b) || (h <= 2 * b);
   endfunction

endpackage

// File: rtl/fs_scan_coord.sv
// Raster row/col counter over the interior pixels; keeps the linear
// address incrementally so no multiplier is needed.
module fs_scan_coord
   import fs_pkg::*;
#(
   parameter int IMG_W  = FS_IMG_W,
   parameter int IMG_H  = FS_IMG_H,
   parameter int BORDER = FS_BORDER,
   parameter int ADDR_W = FS_ADDR_W
) (
   input  logic              clock,
   input  logic              nReset,
   input  logic              init_i,
   input  logic              advance_i,
   output logic              first_o,
   output logic              last_o,
   output logic [ADDR_W-1:0] addr_o
);

   localparam logic [ADDR_W-1:0] EDGE_LO    = ADDR_W'(BORDER);
   localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(IMG_W - 1 - BORDER);
   localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(IMG_H - 1 - BORDER);
   localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BORDER * IMG_W + BORDER);
   // Jump from the last interior column to the first one on the next row.
   localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(2 * BORDER + 1);

   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
      if (init_i) begin
         row_d  = EDGE_LO;
         col_d  = EDGE_LO;
         addr_d = ADDR_FIRST;
      end else if (advance_i) begin
         if (col_q == COL_LAST) begin
            col_d  = EDGE_LO;
            row_d  = row_q + 1'b1;
            addr_d = addr_q + ROW_STEP;
         end else begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         row_q  <= EDGE_LO;
         col_q  <= EDGE_LO;
         addr_q <= ADDR_FIRST;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         addr_q <= addr_d;
      end
   end

   assign first_o = (row_q == EDGE_LO) && (col_q == EDGE_LO);
   assign last_o  = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign addr_o  = addr_q;

endmodule

// File: rtl/fs_scan_ctrl.sv
// FAST-9 frame sequencer: fetch each interior pixel, commit its score.
// Build option FS_SCAN_CLEAR_EN: non-corner pixels are written with score 0.
module fs_scan_ctrl
   import fs_pkg::*;
#(
   parameter int IMG_W  = FS_IMG_W,
   parameter int IMG_H  = FS_IMG_H,
   parameter int BORDER = FS_BORDER,
   parameter int ADDR_W = FS_ADDR_W
) (
   input  logic                  clock,
   input  logic                  nReset,
   input  logic                  start,
   input  logic [FS_THRES_W-1:0] thres_in,
   output logic                  fetch_req,
   output logic [ADDR_W-1:0]     refAddr,
   input  logic                  fetch_ack,
   input  logic                  isCorner,
   input  logic [FS_SCORE_W-1:0] scoreValue,
   output logic [FS_THRES_W-1:0] thres,
   output logic [ADDR_W-1:0]     refScoreAddr,
   output logic [FS_SCORE_W-1:0] scoreData,
   output logic                  wren,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     cornerCount
);

`ifdef FS_SCAN_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif
   localparam bit EMPTY = fs_frame_empty(IMG_W, IMG_H, BORDER);

   fs_scan_state_t        state_q, state_d;
   logic [FS_THRES_W-1:0] thres_q, thres_d;
   logic [FS_SCORE_W-1:0] score_q, score_d;
   logic                  corner_q, corner_d;
   logic [ADDR_W-1:0]     count_q, count_d;
   logic [ADDR_W-1:0]     count_base;
   logic                  coord_init, coord_advance, coord_first, coord_last;
   logic [ADDR_W-1:0]     coord_addr;

   fs_scan_coord #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .BORDER(BORDER),
      .ADDR_W(ADDR_W)
   ) u_coord (
      .clock    (clock),
      .nReset   (nReset),
      .init_i   (coord_init),
      .advance_i(coord_advance),
      .first_o  (coord_first),
      .last_o   (coord_last),
      .addr_o   (coord_addr)
   );

   // The first interior pixel always starts the count afresh.
   assign count_base = coord_first ? '0 : count_q;

   always_comb begin
      state_d       = state_q;
      thres_d       = thres_q;
      score_d       = score_q;
      corner_d      = corner_q;
      count_d       = count_q;
      coord_init    = 1'b0;
      coord_advance = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               thres_d    = thres_in;
               count_d    = '0;
               coord_init = 1'b1;
               state_d    = EMPTY ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (fetch_ack) begin
               corner_d = isCorner;
               score_d  = scoreValue;
               state_d  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            count_d = count_base;
            if (corner_q && (count_base != '1)) begin
               count_d = count_base + 1'b1;
            end
            coord_advance = 1'b1;
            state_d       = coord_last ? ST_DONE : ST_ISSUE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q  <= ST_IDLE;
         thres_q  <= '0;
         score_q  <= '0;
         corner_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         thres_q  <= thres_d;
         score_q  <= score_d;
         corner_q <= corner_d;
         count_q  <= count_d;
      end
   end

   // Outputs decode straight from state so a reset drops them at once.
   assign fetch_req    = (state_q == ST_ISSUE);
   assign refAddr      = (state_q inside {ST_ISSUE, ST_WAIT, ST_WRITE}) ? coord_addr : '0;
   assign wren         = (state_q == ST_WRITE) && (corner_q || CLEAR_EN);
   assign refScoreAddr = (state_q == ST_WRITE) ? coord_addr : '0;
   assign scoreData    = ((state_q == ST_WRITE) && corner_q) ? score_q : '0;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign thres        = thres_q;
   assign cornerCount  = count_q;

endmodule

// File: tb/tb_fs_scan_ctrl.sv
// Scoreboard bench for fs_scan_ctrl on an 8x8 image plus a 6x6 empty-frame instance.
`timescale 1ns/1ps
module tb_fs_scan_ctrl;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int B  = 3;
   localparam int AW = 15;

   logic          clock = 1'b0;
   logic          nReset = 1'b0;
   logic          start, fetch_ack, isCorner;
   logic [7:0]    thres_in, scoreValue;
   logic          fetch_req, wren, busy, done;
   logic [AW-1:0] refAddr, refScoreAddr, cornerCount;
   logic [7:0]    thres, scoreData;

   logic          start_e;
   logic          fetch_req_e, wren_e, busy_e, done_e;
   logic [AW-1:0] refAddr_e, refScoreAddr_e, cornerCount_e;
   logic [7:0]    thres_e, scoreData_e;

   always #5 clock = ~clock;

   fs_scan_ctrl #(.IMG_W(W), .IMG_H(H), .BORDER(B), .ADDR_W(AW)) dut (
      .clock(clock), .nReset(nReset), .start(start), .thres_in(thres_in),
      .fetch_req(fetch_req), .refAddr(refAddr), .fetch_ack(fetch_ack),
      .isCorner(isCorner), .scoreValue(scoreValue), .thres(thres),
      .refScoreAddr(refScoreAddr), .scoreData(scoreData), .wren(wren),
      .busy(busy), .done(done), .cornerCount(cornerCount)
   );

   fs_scan_ctrl #(.IMG_W(6), .IMG_H(6), .BORDER(B), .ADDR_W(AW)) dut_e (
      .clock(clock), .nReset(nReset), .start(start_e), .thres_in(8'h5c),
      .fetch_req(fetch_req_e), .refAddr(refAddr_e), .fetch_ack(1'b1),
      .isCorner(1'b1), .scoreValue(8'hee), .thres(thres_e),
      .refScoreAddr(refScoreAddr_e), .scoreData(scoreData_e), .wren(wren_e),
      .busy(busy_e), .done(done_e), .cornerCount(cornerCount_e)
   );

   int         n_checks = 0;
   int         n_pass = 0;
   int         done_cnt = 0;
   int         exp_cc = 0;
   logic [7:0] exp_thres = 8'h00;
   int         delay_min = 1;
   int         delay_max = 1;
   bit         abort_resp = 1'b0;
   bit         corner_tab [0:63];
   logic [7:0] score_tab [0:63];
   int         fetch_q[$];
   int         wr_addr_q[$];
   int         wr_data_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic miss(input string name, input longint act);
      n_checks++;
      $display("FAIL %s: got %0d where nothing was expected", name, act);
   endtask

   // Monitor: every fetch, write and done is compared against the queues.
   always @(negedge clock) begin
      if (nReset) begin
         if (fetch_req) begin
            if (fetch_q.size() == 0) miss("extra_fetch", refAddr);
            else begin
               chk("fetch_addr", refAddr, fetch_q.pop_front());
               chk("thres", thres, exp_thres);
            end
         end
         if (wren) begin
            if (wr_addr_q.size() == 0) miss("extra_write", refScoreAddr);
            else begin
               chk("write_addr", refScoreAddr, wr_addr_q.pop_front());
               chk("write_data", scoreData, wr_data_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            chk("corner_count", cornerCount, exp_cc);
         end
      end
   end

   // Fetch responder: random ack delay, junk ack outside WAIT.
   initial begin
      fetch_ack  = 1'b0;
      isCorner   = 1'b0;
      scoreValue = 8'h00;
      forever begin
         @(negedge clock);
         if (nReset && fetch_req && !abort_resp) begin
            int a;
            int d;
            a = int'(refAddr);
            d = int'($urandom_range(delay_max, delay_min));
            @(posedge clock); #1;
            fetch_ack = 1'b0;
            for (int k = 1; k < d; k++) begin
               @(negedge clock);
               if (!abort_resp) begin
                  chk("wait_addr_stable", refAddr, a);
                  chk("wait_no_req", fetch_req, 0);
                  chk("wait_no_wren", wren, 0);
               end
               @(posedge clock); #1;
            end
            if (!abort_resp) begin
               fetch_ack  = 1'b1;
               isCorner   = corner_tab[a[5:0]];
               scoreValue = score_tab[a[5:0]];
            end
            @(posedge clock); #1;
            fetch_ack  = 1'($urandom_range(1, 0));
            isCorner   = 1'($urandom_range(1, 0));
            scoreValue = 8'($urandom);
         end
      end
   end

   task automatic set_tab(input int mode);
      for (int i = 0; i < 64; i++) begin
         score_tab[i] = 8'($urandom);
         case (mode)
            0: corner_tab[i] = 1'b0;
            1: begin
               corner_tab[i] = (i == 35);
               if (i == 35) score_tab[i] = 8'h40;
            end
            default: corner_tab[i] = 1'($urandom_range(1, 0));
         endcase
      end
   endtask

   // Reference model: interior raster walk and the write each pixel earns.
   task automatic push_frame(input logic [7:0] thr);
      exp_thres = thr;
      exp_cc    = 0;
      done_cnt  = 0;
      for (int r = B; r <= H - 1 - B; r++) begin
         for (int c = B; c <= W - 1 - B; c++) begin
            int a;
            a = r * W + c;
            fetch_q.push_back(a);
            if (corner_tab[a]) exp_cc++;
`ifdef FS_SCAN_CLEAR_EN
            wr_addr_q.push_back(a);
            wr_data_q.push_back(corner_tab[a] ? int'(score_tab[a]) : 0);
`else
            if (corner_tab[a]) begin
               wr_addr_q.push_back(a);
               wr_data_q.push_back(int'(score_tab[a]));
            end
`endif
         end
      end
   endtask

   task automatic pulse_start(input logic [7:0] thr);
      @(posedge clock); #1;
      start    = 1'b1;
      thres_in = thr;
      @(posedge clock); #1;
      start    = 1'b0;
      thres_in = 8'($urandom);
   endtask

   task automatic run_frame(input logic [7:0] thr, input bit poke);
      int k;
      bit got;
      push_frame(thr);
      pulse_start(thr);
      chk("busy_after_start", busy, 1);
      got = 1'b0;
      for (k = 0; k < 3000 && !got; k++) begin
         if (poke) begin
            start = (k >= 3 && k < 6);
            if (k == 3) thres_in = 8'h30;
         end
         @(posedge clock); #1;
         if (done_cnt != 0) got = 1'b1;
      end
      start = 1'b0;
      if (!got) miss("done_timeout", k);
      repeat (6) @(posedge clock);
      #1;
      chk("done_pulses", done_cnt, 1);
      chk("fetches_left", fetch_q.size(), 0);
      chk("writes_left", wr_addr_q.size(), 0);
      chk("busy_after_done", busy, 0);
      chk("count_hold", cornerCount, exp_cc);
      chk("thres_hold", thres, thr);
      $display("frame thres=%0h corners=%0d done_pulses=%0d", thr, exp_cc, done_cnt);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  k, first_k, pulses, fe, we;
      bit  got;
      start    = 1'b0;
      start_e  = 1'b0;
      thres_in = 8'h00;
      set_tab(0);
      repeat (3) @(posedge clock);
      #1;
      chk("rst_fetch_req", fetch_req, 0);
      chk("rst_refAddr", refAddr, 0);
      chk("rst_wren", wren, 0);
      chk("rst_scoreAddr", refScoreAddr, 0);
      chk("rst_scoreData", scoreData, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", cornerCount, 0);
      chk("rst_thres", thres, 0);
      chk("rst_busy_e", busy_e, 0);
      nReset = 1'b1;
      @(posedge clock); #1;

      delay_min = 1; delay_max = 1;
      set_tab(0); run_frame(8'h22, 1'b0);
      set_tab(1); run_frame(8'h10, 1'b0);
      delay_min = 5; delay_max = 5;
      set_tab(2); run_frame(8'($urandom), 1'b0);
      delay_min = 3; delay_max = 6;
      set_tab(2); run_frame(8'h10, 1'b1);
      for (int i = 0; i < 6; i++) begin
         delay_min = 1; delay_max = 4;
         set_tab(2); run_frame(8'($urandom), 1'b0);
      end

      // Reset while waiting on pixel 28, then rescan from the top.
      delay_min = 8; delay_max = 8;
      set_tab(2);
      push_frame(8'h5a);
      pulse_start(8'h5a);
      got = 1'b0;
      for (k = 0; k < 200 && !got; k++) begin
         if (fetch_q.size() == 2) got = 1'b1;
         else begin @(posedge clock); #1; end
      end
      if (!got) miss("reach_pixel28_timeout", k);
      #1;
      abort_resp = 1'b1;
      nReset = 1'b0;
      #1;
      chk("arst_fetch_req", fetch_req, 0);
      chk("arst_refAddr", refAddr, 0);
      chk("arst_wren", wren, 0);
      chk("arst_busy", busy, 0);
      chk("arst_thres", thres, 0);
      chk("arst_count", cornerCount, 0);
      $display("async reset during pixel 28 wait applied");
      fetch_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      repeat (3) @(posedge clock);
      #1;
      nReset = 1'b1;
      repeat (15) @(posedge clock);
      #1;
      abort_resp = 1'b0;
      delay_min = 1; delay_max = 3;
      set_tab(2); run_frame(8'h77, 1'b0);

      // Empty frame on the 6x6 instance.
      @(posedge clock); #1;
      start_e = 1'b1;
      @(posedge clock); #1;
      start_e = 1'b0;
      first_k = 0; pulses = 0; fe = 0; we = 0;
      for (int j = 1; j <= 6; j++) begin
         @(negedge clock);
         if (done_e) begin
            pulses++;
            if (first_k == 0) first_k = j;
         end
         if (fetch_req_e) fe++;
         if (wren_e) we++;
      end
      chk("empty_done_cycle", first_k, 1);
      chk("empty_done_pulses", pulses, 1);
      chk("empty_fetches", fe, 0);
      chk("empty_writes", we, 0);
      chk("empty_busy_end", busy_e, 0);
      chk("empty_count", cornerCount_e, 0);
      chk("empty_thres", thres_e, 8'h5c);
      $display("empty frame done_cycle=%0d pulses=%0d", first_k, pulses);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
